basic_control_unit: RTL
=======================

Name: basic_control_unit

Overview:
- Hardwired sequencer for the 16-bit Basic Computer datapath.
- Runs a sequence counter (T0..T6) through fetch, decode, indirect and execute for the memory-reference and register-reference instructions.
- Drives every datapath load/increment/clear/bus-select/memory strobe, plus alu_op.
- Owns the E (extend) and S (run) flip-flops.

Parameters:
- AW, 12, address width (AR/PC)
- DW, 16, data width (IR/AC/DR)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; starts execution when halted
- ir  input  DW  datapath IR
- ac  input  DW  datapath AC
- dr  input  DW  datapath DR
- co  input  1  ALU carry-out
- reset_ar, reset_pc, reset_dr, reset_tr, reset_ac  output  1 each  register clears
- write_ar, write_pc, write_dr, write_tr, write_ir, write_ac  output  1 each  register loads
- increment_ar, increment_pc, increment_dr, increment_tr, increment_ac  output  1 each  register increments
- read_ar, read_pc, read_dr, read_tr, read_ir, read_ac  output  1 each  bus source selects (at most one high)
- memory_read, memory_write  output  1 each  memory onto bus / memory write from bus
- alu_op  output  3  ALU operation
- e  output  1  E flip-flop, to ALU E input
- running  output  1  S flip-flop
- sc  output  3  current timing step (debug)

Behaviour:
- States: INIT, HALT, T0..T6. Async reset (reset=0) -> INIT, e=0, running=0, sc=0.
- All strobes are combinational from state, latched I/D, ir, ac, dr. All strobes are 0 except in the listed cases. alu_op defaults to 111.
- INIT (1 cycle): assert reset_ar, reset_pc, reset_dr, reset_tr, reset_ac -> HALT.
- HALT: no strobes. start=1 -> T0, running=1.
- Memory read is combinational from AR (bus valid same cycle). Memory write commits at the clock edge.
- alu_op encoding:
  - 000 AC&DR
  - 001 AC+DR
  - 010 pass DR
  - 011 ~AC
  - 100 shift right with E into bit15
  - 101 shift left with E into bit0
  - 11x pass AC
- Fetch/decode:
  - T0: read_pc, write_ar.
  - T1: memory_read, write_ir, increment_pc.
  - T2: read_ir, write_ar; latch I=ir[15], D=ir[14:12].
- T3:
  - D=7, I=0: register-reference execute, then T0.
  - D=7, I=1: I/O unsupported, no strobes, -> T0.
  - D<7, I=1: memory_read, write_ar.
  - D<7, I=0: idle.
  - Otherwise -> T4.
- T4:
  - D0/D1/D2/D6: memory_read, write_dr.
  - D3 STA: read_ac, memory_write, -> T0.
  - D4 BUN: read_ar, write_pc, -> T0.
  - D5 BSA: read_pc, memory_write, increment_ar.
- T5, then T0 except ISZ:
  - D0: alu_op 000, write_ac.
  - D1: alu_op 001, write_ac, E<=co.
  - D2: alu_op 010, write_ac.
  - D5: read_ar, write_pc.
  - D6: increment_dr, -> T6.
- T6 (ISZ): read_dr, memory_write; increment_pc if dr==0; -> T0.
- Register-reference (T3, ir[11:0]):
  - AC ops, priority CLA(800)>CMA(200)>CIR(080)>CIL(040)>INC(020), only the highest one applied:
    - CLA: reset_ac.
    - CMA: alu_op 011, write_ac.
    - CIR: alu_op 100, write_ac, E<=ac[0].
    - CIL: alu_op 101, write_ac, E<=ac[15].
    - INC: increment_ac.
  - CLE(400): E<=0; CME(100): E<=~E. CIR/CIL E update overrides CLE/CME.
  - Skips SPA(010) ac[15]==0, SNA(008) ac[15]==1, SZA(004) ac==0, SZE(002) E==0: OR of all true selected conditions -> single increment_pc.
  - HLT(001): running<=0, -> HALT after this cycle.
- start ignored outside HALT. HALT keeps PC, so start resumes at the next instruction.
- Reset asserted mid-instruction: immediate return to INIT, strobes drop asynchronously, partial instruction abandoned.
- PC/AR wrap (FFF+1=000) is the datapath's job; no special action here.

Test Plan:
- Reset pulse, release -> one INIT cycle with all five reset_* high, then HALT (running=0, no strobes); start -> next cycle sc=0 with read_pc+write_ar.
- LDA direct 0x2010, M[010]=0x1234 -> T0..T5 strobes as specified, T5 alu_op=010 write_ac, AC=0x1234, next instruction at cycle 7, PC+1.
- ADD indirect 0x9020, M[020]=0x0050, M[050]=0xFFFF, AC=0x0001 -> T3 memory_read+write_ar, T5 alu_op=001, AC=0x0000, e=1.
- ISZ 0x6030, M[030]=0xFFFF -> T6 read_dr+memory_write+increment_pc, M[030]=0x0000, PC skips by 2, 7 cycles total; with M[030]=0x0005 no skip.
- BSA 0x5040 at PC=0x100 -> M[040]=0x101, PC=0x041; then register-ref 0x7844 (CLA|CIL|SZA) with AC=0x8000, E=1 -> only reset_ac, E<=1, no skip since pre-clear ac!=0.
- HLT 0x7001 -> running falls, HALT holds with no strobes for 20 cycles; start resumes at the next PC. Reset asserted during T4 of an STA -> memory_write deasserts immediately, state INIT.

Source files
------------

// File: rtl/basic_control_unit.sv
// Hardwired sequencer for the 16-bit Basic Computer: steps T0..T6 through fetch,
// decode, indirect and execute, and owns the E and S flip-flops.
module basic_control_unit #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] ir,
  input  logic [DW-1:0] ac,
  input  logic [DW-1:0] dr,
  input  logic          co,
  output logic          reset_ar,
  output logic          reset_pc,
  output logic          reset_dr,
  output logic          reset_tr,
  output logic          reset_ac,
  output logic          write_ar,
  output logic          write_pc,
  output logic          write_dr,
  output logic          write_tr,
  output logic          write_ir,
  output logic          write_ac,
  output logic          increment_ar,
  output logic          increment_pc,
  output logic          increment_dr,
  output logic          increment_tr,
  output logic          increment_ac,
  output logic          read_ar,
  output logic          read_pc,
  output logic          read_dr,
  output logic          read_tr,
  output logic          read_ir,
  output logic          read_ac,
  output logic          memory_read,
  output logic          memory_write,
  output logic [2:0]    alu_op,
  output logic          e,
  output logic          running,
  output logic [2:0]    sc
);

  typedef enum logic [3:0] {
    S_INIT, S_HALT, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_t;

  state_t      state_q, state_d;
  logic        i_q, i_d;
  logic [2:0]  d_q, d_d;
  logic        e_q, e_d;
  logic        s_q, s_d;
  logic [AW-1:0] rr;
  logic        skip;

  assign rr      = ir[AW-1:0];
  assign e       = e_q;
  assign running = s_q;

  // Skip conditions are ORed so several true selections still give one PC increment.
  assign skip = (rr[4] & ~ac[DW-1]) | (rr[3] & ac[DW-1]) |
                (rr[2] & (ac == '0)) | (rr[1] & ~e_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
      i_q     <= 1'b0;
      d_q     <= '0;
      e_q     <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      d_q     <= d_d;
      e_q     <= e_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    d_d          = d_q;
    e_d          = e_q;
    s_d          = s_q;
    reset_ar     = 1'b0;
    reset_pc     = 1'b0;
    reset_dr     = 1'b0;
    reset_tr     = 1'b0;
    reset_ac     = 1'b0;
    write_ar     = 1'b0;
    write_pc     = 1'b0;
    write_dr     = 1'b0;
    write_tr     = 1'b0;
    write_ir     = 1'b0;
    write_ac     = 1'b0;
    increment_ar = 1'b0;
    increment_pc = 1'b0;
    increment_dr = 1'b0;
    increment_tr = 1'b0;
    increment_ac = 1'b0;
    read_ar      = 1'b0;
    read_pc      = 1'b0;
    read_dr      = 1'b0;
    read_tr      = 1'b0;
    read_ir      = 1'b0;
    read_ac      = 1'b0;
    memory_read  = 1'b0;
    memory_write = 1'b0;
    alu_op       = 3'b111;
    sc           = 3'd0;
    case (state_q)
      S_INIT: begin
        reset_ar = 1'b1;
        reset_pc = 1'b1;
        reset_dr = 1'b1;
        reset_tr = 1'b1;
        reset_ac = 1'b1;
        state_d  = S_HALT;
      end
      S_HALT: begin
        if (start) begin
          state_d = S_T0;
          s_d     = 1'b1;
        end
      end
      S_T0: begin
        sc       = 3'd0;
        read_pc  = 1'b1;
        write_ar = 1'b1;
        state_d  = S_T1;
      end
      S_T1: begin
        sc           = 3'd1;
        memory_read  = 1'b1;
        write_ir     = 1'b1;
        increment_pc = 1'b1;
        state_d      = S_T2;
      end
      S_T2: begin
        sc       = 3'd2;
        read_ir  = 1'b1;
        write_ar = 1'b1;
        i_d      = ir[DW-1];
        d_d      = ir[DW-2:DW-4];
        state_d  = S_T3;
      end
      S_T3: begin
        sc = 3'd3;
        if (d_q == 3'd7) begin
          state_d = S_T0;
          if (!i_q) begin
            // E from CIR/CIL is assigned last so it overrides CLE/CME.
            if (rr[10]) e_d = 1'b0;
            if (rr[8])  e_d = ~e_d;
            if (rr[11]) begin
              reset_ac = 1'b1;
            end else if (rr[9]) begin
              alu_op   = 3'b011;
              write_ac = 1'b1;
            end else if (rr[7]) begin
              alu_op   = 3'b100;
              write_ac = 1'b1;
              e_d      = ac[0];
            end else if (rr[6]) begin
              alu_op   = 3'b101;
              write_ac = 1'b1;
              e_d      = ac[DW-1];
            end else if (rr[5]) begin
              increment_ac = 1'b1;
            end
            increment_pc = skip;
            if (rr[0]) begin
              s_d     = 1'b0;
              state_d = S_HALT;
            end
          end
        end else begin
          if (i_q) begin
            memory_read = 1'b1;
            write_ar    = 1'b1;
          end
          state_d = S_T4;
        end
      end
      S_T4: begin
        sc      = 3'd4;
        state_d = S_T0;
        case (d_q)
          3'd0, 3'd1, 3'd2, 3'd6: begin
            memory_read = 1'b1;
            write_dr    = 1'b1;
            state_d     = S_T5;
          end
          3'd3: begin
            read_ac      = 1'b1;
            memory_write = 1'b1;
          end
          3'd4: begin
            read_ar  = 1'b1;
            write_pc = 1'b1;
          end
          3'd5: begin
            read_pc      = 1'b1;
            memory_write = 1'b1;
            increment_ar = 1'b1;
            state_d      = S_T5;
          end
          default: ;
        endcase
      end
      S_T5: begin
        sc      = 3'd5;
        state_d = S_T0;
        case (d_q)
          3'd0: begin
            alu_op   = 3'b000;
            write_ac = 1'b1;
          end
          3'd1: begin
            alu_op   = 3'b001;
            write_ac = 1'b1;
            e_d      = co;
          end
          3'd2: begin
            alu_op   = 3'b010;
            write_ac = 1'b1;
          end
          3'd5: begin
            read_ar  = 1'b1;
            write_pc = 1'b1;
          end
          3'd6: begin
            increment_dr = 1'b1;
            state_d      = S_T6;
          end
          default: ;
        endcase
      end
      S_T6: begin
        sc           = 3'd6;
        read_dr      = 1'b1;
        memory_write = 1'b1;
        increment_pc = (dr == '0);
        state_d      = S_T0;
      end
      default: state_d = S_INIT;
    endcase
  end

endmodule
